// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WQ   = 2'd1,
        HELD = 2'd2,
        WR   = 2'd3
    } deb_state_t;

    // True when a counter of cnt_w bits can hold the largest of the three counts.
    function automatic bit cnt_w_fits(input int cnt_w, input int wait_cnt,
                                      input int repeat_dly, input int repeat_rate);
        longint limit;
        int     biggest;
        biggest = wait_cnt;
        if (repeat_dly > biggest) biggest = repeat_dly;
        if (repeat_rate > biggest) biggest = repeat_rate;
        limit = longint'(1) << cnt_w;
        return limit > longint'(biggest);
    endfunction

endpackage

// File: rtl/multi_btn_debounce_if.sv
// Button bundle between the board push-buttons and the game-control logic.
interface multi_btn_debounce_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] Btn;
    logic [N_BTN-1:0] Btn_level;
    logic [N_BTN-1:0] Btn_pulse;
    logic [N_BTN-1:0] Btn_rel_pulse;

    modport master (output Btn, input Btn_level, input Btn_pulse, input Btn_rel_pulse);
    modport slave  (input Btn, output Btn_level, output Btn_pulse, output Btn_rel_pulse);
endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, qualification FSM, press/release
// pulses and an optional auto-repeat counter while the button is held.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int WAIT_CNT    = 2000,
    parameter int REPEAT_DLY  = 12000,
    parameter int REPEAT_RATE = 3000,
    parameter int CNT_W       = 14,
    parameter bit REPEAT_EN   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse,
    output logic rel_pulse
);

    localparam logic [CNT_W-1:0] WAIT_V   = CNT_W'(WAIT_CNT);
    localparam logic [CNT_W-1:0] DLY_V    = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] RELOAD_V = CNT_W'(REPEAT_DLY - REPEAT_RATE + 1);
    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    deb_state_t       next_state;
    logic [CNT_W-1:0] qual_cnt;
    logic [CNT_W-1:0] qual_cnt_next;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_next;
    logic             level_next;
    logic             pulse_next;
    logic             rel_next;

    // Bring the raw asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: any drop of the synchronized level during qualification restarts it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sync2) next_state = WQ;
            end
            WQ: begin
                if (!sync2) next_state = IDLE;
                else if (qual_cnt == WAIT_V) next_state = HELD;
            end
            HELD: begin
                if (!sync2) next_state = WR;
            end
            WR: begin
                if (sync2) next_state = HELD;
                else if (qual_cnt == WAIT_V) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counter updates and next values of the registered outputs; pulses default low.
    always_comb begin
        qual_cnt_next = qual_cnt;
        rep_cnt_next  = rep_cnt;
        level_next    = level;
        pulse_next    = 1'b0;
        rel_next      = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) qual_cnt_next = '0;
            end
            WQ: begin
                if (sync2) begin
                    if (qual_cnt == WAIT_V) begin
                        pulse_next   = 1'b1;
                        level_next   = 1'b1;
                        rep_cnt_next = '0;
                    end else begin
                        qual_cnt_next = qual_cnt + ONE_V;
                    end
                end
            end
            HELD: begin
                if (!sync2) begin
                    qual_cnt_next = '0;
                end else if (REPEAT_EN) begin
                    if (rep_cnt == DLY_V) begin
                        pulse_next   = 1'b1;
                        rep_cnt_next = RELOAD_V;
                    end else begin
                        rep_cnt_next = rep_cnt + ONE_V;
                    end
                end
            end
            WR: begin
                if (sync2) begin
                    rep_cnt_next = '0;
                end else if (qual_cnt == WAIT_V) begin
                    rel_next   = 1'b1;
                    level_next = 1'b0;
                end else begin
                    qual_cnt_next = qual_cnt + ONE_V;
                end
            end
            default: begin
                qual_cnt_next = '0;
            end
        endcase
    end

    // Counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qual_cnt  <= '0;
            rep_cnt   <= '0;
            level     <= 1'b0;
            pulse     <= 1'b0;
            rel_pulse <= 1'b0;
        end else begin
            qual_cnt  <= qual_cnt_next;
            rep_cnt   <= rep_cnt_next;
            level     <= level_next;
            pulse     <= pulse_next;
            rel_pulse <= rel_next;
        end
    end

endmodule

// File: rtl/multi_btn_debounce.sv
// N independent button debouncers sharing one slow control clock.
module multi_btn_debounce
    import debounce_pkg::*;
#(
    parameter int               N_BTN       = 5,
    parameter int               WAIT_CNT    = 2000,
    parameter int               REPEAT_DLY  = 12000,
    parameter int               REPEAT_RATE = 3000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = {N_BTN{1'b0}},
    parameter int               CNT_W       = 14
) (
    input logic                CLK,
    input logic                RESET_N,
    multi_btn_debounce_if.slave bus
);

    // Counters must never wrap and repeats must fit inside the initial delay.
    if (!cnt_w_fits(CNT_W, WAIT_CNT, REPEAT_DLY, REPEAT_RATE)) begin : g_cnt_w_check
        $error("multi_btn_debounce: CNT_W too narrow for WAIT_CNT/REPEAT_DLY/REPEAT_RATE");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DLY) begin : g_rate_check
        $error("multi_btn_debounce: REPEAT_RATE must be in 1..REPEAT_DLY");
    end

    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] pulse_vec;
    logic [N_BTN-1:0] rel_vec;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .WAIT_CNT    (WAIT_CNT),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE),
            .CNT_W       (CNT_W),
            .REPEAT_EN   (REPEAT_MASK[g])
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RESET_N),
            .btn       (bus.Btn[g]),
            .level     (level_vec[g]),
            .pulse     (pulse_vec[g]),
            .rel_pulse (rel_vec[g])
        );
    end

    assign bus.Btn_level     = level_vec;
    assign bus.Btn_pulse     = pulse_vec;
    assign bus.Btn_rel_pulse = rel_vec;

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Bench for multi_btn_debounce: directed scenarios plus random button activity,
// all compared cycle by cycle against a run-length reference model.
module tb_multi_btn_debounce;

    localparam int               N_BTN       = 3;
    localparam int               WAIT_CNT    = 4;
    localparam int               REPEAT_DLY  = 10;
    localparam int               REPEAT_RATE = 3;
    localparam logic [N_BTN-1:0] REPEAT_MASK = 3'b010;
    localparam int               QUAL_EDGES  = WAIT_CNT + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multi_btn_debounce_if #(.N_BTN(N_BTN)) bus ();

    multi_btn_debounce #(
        .N_BTN       (N_BTN),
        .WAIT_CNT    (WAIT_CNT),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE),
        .REPEAT_MASK (REPEAT_MASK),
        .CNT_W       (14)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // Free-running control clock.
    always #5 clk = ~clk;

    logic [N_BTN-1:0] m_s1;
    logic [N_BTN-1:0] m_s2;
    logic [N_BTN-1:0] m_level;
    logic [N_BTN-1:0] exp_pulse;
    logic [N_BTN-1:0] exp_rel;
    int               m_run  [N_BTN];
    int               m_hold [N_BTN];

    int checks = 0;
    int errors = 0;

    int               edge_no = -1;
    int               pulse_cnt   [N_BTN];
    int               rel_cnt     [N_BTN];
    int               first_pulse [N_BTN];
    int               last_pulse  [N_BTN];
    int               last_rel    [N_BTN];
    int               probe_edge = -100;
    logic [N_BTN-1:0] probe_val  = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1      = '0;
        m_s2      = '0;
        m_level   = '0;
        exp_pulse = '0;
        exp_rel   = '0;
        for (int c = 0; c < N_BTN; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
    endtask

    // Level flips once the synchronized input has disagreed with it for
    // QUAL_EDGES consecutive edges; held time since the press (or since an
    // aborted release) drives the auto-repeat schedule.
    task automatic model_step(input logic [N_BTN-1:0] raw);
        exp_pulse = '0;
        exp_rel   = '0;
        for (int c = 0; c < N_BTN; c++) begin
            if (m_s2[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == QUAL_EDGES) begin
                    m_level[c]   = m_s2[c];
                    exp_pulse[c] = m_s2[c];
                    exp_rel[c]   = !m_s2[c];
                    m_run[c]     = 0;
                    m_hold[c]    = 0;
                end else begin
                    m_hold[c] = -1;
                end
            end else begin
                m_run[c] = 0;
                if (m_level[c] && REPEAT_MASK[c]) begin
                    m_hold[c]++;
                    if (m_hold[c] == REPEAT_DLY + 1)
                        exp_pulse[c] = 1'b1;
                    else if (m_hold[c] > REPEAT_DLY + 1 &&
                             (m_hold[c] - REPEAT_DLY - 1) % REPEAT_RATE == 0)
                        exp_pulse[c] = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic mark();
        edge_no = -1;
        for (int c = 0; c < N_BTN; c++) begin
            pulse_cnt[c]   = 0;
            rel_cnt[c]     = 0;
            first_pulse[c] = -1;
            last_pulse[c]  = -1;
            last_rel[c]    = -1;
        end
    endtask

    task automatic applyStimulus(input logic [N_BTN-1:0] val, input int n);
        for (int k = 0; k < n; k++) begin
            bus.Btn = val;
            @(posedge clk);
            edge_no++;
            model_step(val);
            #1;
            checkOutput("level", 32'(bus.Btn_level), 32'(m_level));
            checkOutput("pulse", 32'(bus.Btn_pulse), 32'(exp_pulse));
            checkOutput("rel", 32'(bus.Btn_rel_pulse), 32'(exp_rel));
            for (int c = 0; c < N_BTN; c++) begin
                if (bus.Btn_pulse[c]) begin
                    pulse_cnt[c]++;
                    if (first_pulse[c] < 0) first_pulse[c] = edge_no;
                    last_pulse[c] = edge_no;
                end
                if (bus.Btn_rel_pulse[c]) begin
                    rel_cnt[c]++;
                    last_rel[c] = edge_no;
                end
            end
            if (edge_no == probe_edge) probe_val = bus.Btn_pulse;
        end
    endtask

    // Assert reset between edges, confirm outputs clear at once, then release.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_level"}, 32'(bus.Btn_level), 32'd0);
        checkOutput({tag, "_pulse"}, 32'(bus.Btn_pulse), 32'd0);
        checkOutput({tag, "_rel"}, 32'(bus.Btn_rel_pulse), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.Btn = '0;
        model_reset();
        mark();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_level", 32'(bus.Btn_level), 32'd0);
        checkOutput("reset_pulse", 32'(bus.Btn_pulse), 32'd0);
        checkOutput("reset_rel", 32'(bus.Btn_rel_pulse), 32'd0);
        #2;
        rst_n = 1'b1;

        $display("[TB] clean press on channel 0");
        mark();
        applyStimulus(3'b001, 20);
        checkOutput("press_edge", 32'(first_pulse[0]), 32'd7);
        checkOutput("press_count", 32'(pulse_cnt[0]), 32'd1);
        checkOutput("press_level", 32'(bus.Btn_level[0]), 32'd1);
        mark();
        applyStimulus(3'b000, 12);
        checkOutput("release_edge", 32'(last_rel[0]), 32'd7);
        checkOutput("release_count", 32'(rel_cnt[0]), 32'd1);

        $display("[TB] bouncy press on channel 0");
        mark();
        for (int b = 0; b < 3; b++) begin
            applyStimulus(3'b001, 2);
            applyStimulus(3'b000, 1);
        end
        applyStimulus(3'b001, 15);
        checkOutput("bounce_count", 32'(pulse_cnt[0]), 32'd1);
        checkOutput("bounce_edge", 32'(first_pulse[0]), 32'd16);
        applyStimulus(3'b000, 12);

        $display("[TB] auto-repeat on channel 1");
        mark();
        applyStimulus(3'b010, 40);
        checkOutput("repeat_first", 32'(first_pulse[1]), 32'd7);
        checkOutput("repeat_count", 32'(pulse_cnt[1]), 32'd9);
        checkOutput("repeat_last", 32'(last_pulse[1]), 32'd39);
        mark();
        applyStimulus(3'b000, 12);
        checkOutput("repeat_rel_edge", 32'(last_rel[1]), 32'd7);
        checkOutput("repeat_rel_count", 32'(rel_cnt[1]), 32'd1);
        checkOutput("repeat_tail_pulses", 32'(pulse_cnt[1]), 32'd0);

        $display("[TB] release glitch on channel 0");
        applyStimulus(3'b001, 12);
        mark();
        applyStimulus(3'b000, 3);
        applyStimulus(3'b001, 1);
        applyStimulus(3'b000, 15);
        checkOutput("glitch_rel_count", 32'(rel_cnt[0]), 32'd1);
        checkOutput("glitch_rel_edge", 32'(last_rel[0]), 32'd11);

        $display("[TB] reset during qualification and while held");
        applyStimulus(3'b001, 4);
        do_reset("rst_wq");
        mark();
        applyStimulus(3'b001, 12);
        checkOutput("rst_wq_press_edge", 32'(first_pulse[0]), 32'd7);
        do_reset("rst_held");
        mark();
        applyStimulus(3'b001, 12);
        checkOutput("rst_held_press_edge", 32'(first_pulse[0]), 32'd7);
        checkOutput("rst_held_press_count", 32'(pulse_cnt[0]), 32'd1);
        applyStimulus(3'b000, 12);

        $display("[TB] simultaneous press on all channels");
        mark();
        probe_edge = 7;
        applyStimulus(3'b111, 10);
        checkOutput("simul_pulse", 32'(probe_val), 32'(3'b111));
        probe_edge = -100;
        applyStimulus(3'b000, 12);

        $display("[TB] random activity");
        for (int r = 0; r < 200; r++) begin
            logic [N_BTN-1:0] val;
            int               len;
            val = N_BTN'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(8, 30);
            else len = $urandom_range(1, 6);
            applyStimulus(val, len);
            if ($urandom_range(0, 40) == 0) do_reset("rst_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
